dcache: RTL and testbench
=========================

DCACHE -- requirements
Module: dcache

Interface
REQ-001 The block SHALL have no parameters; geometry is fixed at 8 blocks x 4 bytes, direct-mapped, write-back.
REQ-002 CLK  input  1  single system clock; all state updates on posedge CLK.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 READ  input  1  CPU load request, held until BUSYWAIT low.
REQ-005 WRITE  input  1  CPU store request, held until BUSYWAIT low.
REQ-006 ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 WRITEDATA  input  8  CPU store data.
REQ-008 READDATA  output  8  CPU load data.
REQ-009 BUSYWAIT  output  1  CPU stall; CPU holds PC and request while high.
REQ-010 MEM_READ  output  1  memory block-read request.
REQ-011 MEM_WRITE  output  1  memory block-write request.
REQ-012 MEM_ADDRESS  output  6  memory block address {tag,index}.
REQ-013 MEM_WRITEDATA  output  32  block to memory, byte0 in [7:0].
REQ-014 MEM_READDATA  input  32  block from memory, byte0 in [7:0].
REQ-015 MEM_BUSYWAIT  input  1  memory busy; a transfer completes on the first posedge sampling it low while a request is asserted.

Function
REQ-016 Storage SHALL be per block: valid bit, dirty bit, 3-bit tag, 32-bit data.
REQ-017 Hit SHALL be valid[index] AND tag[index]==ADDRESS[7:5], evaluated combinationally.
REQ-018 READDATA SHALL equal the byte selected by offset from data[index] combinationally, regardless of hit.
REQ-019 FSM states SHALL be IDLE, WRITEBACK, FETCH, UPDATE; state is registered.
REQ-020 IDLE: request plus hit -> stay IDLE, BUSYWAIT 0; request plus miss plus dirty -> WRITEBACK; request plus miss plus clean -> FETCH; no request -> IDLE.
REQ-021 BUSYWAIT SHALL be high whenever (READ or WRITE) and not (state==IDLE and hit).
REQ-022 Write hit in IDLE SHALL write WRITEDATA into the selected byte and set dirty at the same posedge; no extra latency.
REQ-023 WRITEBACK: MEM_WRITE=1, MEM_ADDRESS={stored tag,index}, MEM_WRITEDATA=data[index]; advance to FETCH on MEM_BUSYWAIT low.
REQ-024 FETCH: MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2]; on MEM_BUSYWAIT low, latch MEM_READDATA and go to UPDATE.
REQ-025 UPDATE (1 cycle): write latched block, tag=ADDRESS[7:5], valid=1, dirty=0; return to IDLE, where the access completes as a hit.
REQ-026 MEM_READ and MEM_WRITE SHALL never be high simultaneously; both 0 outside FETCH/WRITEBACK.
REQ-027 READ and WRITE both high SHALL be treated as WRITE.
REQ-028 Request dropped mid-miss SHALL not abort the miss; the fill completes and FSM returns to IDLE.
REQ-029 Miss latency (clean) SHALL be mem latency + 2 cycles; dirty adds one write-back transfer.

Reset
REQ-030 RESET high SHALL immediately clear all valid and dirty bits and force state IDLE, MEM_READ=0, MEM_WRITE=0, BUSYWAIT per REQ-021 with all blocks invalid.
REQ-031 Reset mid-WRITEBACK or mid-FETCH SHALL abandon the transfer; data array contents need not be cleared.

Structure
REQ-032 State encodings, geometry constants and field positions SHALL reside in the shared dcache package/include.
REQ-033 One sub-module dcache_fsm (state register, next-state, memory-side outputs) SHALL be instantiated; arrays stay in dcache.

Verification
REQ-034 After reset, READ addr 0x00 -> BUSYWAIT 1, MEM_READ with MEM_ADDRESS 0x00; memory returns 0x44332211 after 5 cycles; UPDATE, then READDATA 0x11, BUSYWAIT 0.
REQ-035 Then READ 0x03 -> hit, BUSYWAIT 0 same cycle, READDATA 0x44, no memory request.
REQ-036 WRITE 0x01 data 0xAA (hit) -> BUSYWAIT 0, next READ 0x01 -> 0xAA, dirty[0]=1.
REQ-037 READ 0x20 (same index, tag 1) -> MEM_WRITE at MEM_ADDRESS 0x00 data 0x4433AA11, then MEM_READ at 0x08; never both high.
REQ-038 RESET asserted during FETCH -> MEM_READ 0 before next posedge, state IDLE, subsequent READ 0x00 misses.
REQ-039 READ and WRITE both high on hit addr 0x02 data 0x5A -> byte written, READDATA 0x5A next cycle.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry, address field positions and FSM encodings for the
// 8-block direct-mapped write-back data cache.
package dcache_pkg;

    localparam int NUM_BLOCKS = 8;
    localparam int TAG_W      = 3;
    localparam int IDX_W      = 3;
    localparam int OFF_W      = 2;
    localparam int TAG_LSB    = 5;
    localparam int IDX_LSB    = 2;
    localparam int OFF_LSB    = 0;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FETCH     = 2'd2;
    localparam logic [1:0] ST_UPDATE    = 2'd3;

    function automatic logic [7:0] sel_byte(
        input logic [31:0]      blk,
        input logic [OFF_W-1:0] off
    );
        return blk[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dcache_fsm.sv
// Miss-handling controller: state register, next-state logic and the
// memory-side request/address/data outputs.
module dcache_fsm
    import dcache_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             hit,
    input  logic             dirty,
    input  logic             mem_busywait,
    input  logic [TAG_W-1:0] addr_tag,
    input  logic [IDX_W-1:0] addr_idx,
    input  logic [TAG_W-1:0] stored_tag,
    input  logic [31:0]      block_data,
    output logic [1:0]       state,
    output logic             mem_read,
    output logic             mem_write,
    output logic [5:0]       mem_address,
    output logic [31:0]      mem_writedata
);

    logic [1:0] state_q;
    logic [1:0] state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req && !hit) begin
                    state_d = dirty ? ST_WRITEBACK : ST_FETCH;
                end
            end
            ST_WRITEBACK: begin
                if (!mem_busywait) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!mem_busywait) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write-back targets the evicted block, fetch targets the requested one.
    assign state         = state_q;
    assign mem_write     = (state_q == ST_WRITEBACK);
    assign mem_read      = (state_q == ST_FETCH);
    assign mem_address   = mem_write ? {stored_tag, addr_idx}
                                     : {addr_tag, addr_idx};
    assign mem_writedata = block_data;

endmodule

// File: rtl/dcache.sv
// 8 x 4-byte direct-mapped write-back data cache: tag/data arrays,
// hit detection and CPU-side datapath around the miss FSM.
module dcache
    import dcache_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);

    logic [NUM_BLOCKS-1:0]            valid_q, valid_d;
    logic [NUM_BLOCKS-1:0]            dirty_q, dirty_d;
    logic [NUM_BLOCKS-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [NUM_BLOCKS-1:0][31:0]      data_q, data_d;
    logic [31:0]                      fill_q, fill_d;

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             req;
    logic             hit;
    logic [1:0]       state;

    assign tag = ADDRESS[TAG_LSB +: TAG_W];
    assign idx = ADDRESS[IDX_LSB +: IDX_W];
    assign off = ADDRESS[OFF_LSB +: OFF_W];
    assign req = READ | WRITE;
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    assign READDATA = sel_byte(data_q[idx], off);
    assign BUSYWAIT = req && !((state == ST_IDLE) && hit);

    dcache_fsm u_fsm (
        .clk           (CLK),
        .rst           (RESET),
        .req           (req),
        .hit           (hit),
        .dirty         (dirty_q[idx]),
        .mem_busywait  (MEM_BUSYWAIT),
        .addr_tag      (tag),
        .addr_idx      (idx),
        .stored_tag    (tag_q[idx]),
        .block_data    (data_q[idx]),
        .state         (state),
        .mem_read      (MEM_READ),
        .mem_write     (MEM_WRITE),
        .mem_address   (MEM_ADDRESS),
        .mem_writedata (MEM_WRITEDATA)
    );

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        fill_d  = fill_q;
        // WRITE wins when both requests are raised together.
        if ((state == ST_IDLE) && hit && WRITE) begin
            data_d[idx][{off, 3'b000} +: 8] = WRITEDATA;
            dirty_d[idx] = 1'b1;
        end
        if ((state == ST_FETCH) && !MEM_BUSYWAIT) begin
            fill_d = MEM_READDATA;
        end
        if (state == ST_UPDATE) begin
            data_d[idx]  = fill_q;
            tag_d[idx]   = tag;
            valid_d[idx] = 1'b1;
            dirty_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Payload arrays survive reset; valid bits alone gate their use.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        fill_q <= fill_d;
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: directed scenarios then random traffic
// against a cache/memory reference model with a fixed-latency memory.
module tb_dcache;

    localparam int LAT = 5;

    logic        CLK;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [7:0]  ADDRESS;
    logic [7:0]  WRITEDATA;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    int n_assert = 0;
    int n_fail   = 0;

    dcache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .READ          (READ),
        .WRITE         (WRITE),
        .ADDRESS       (ADDRESS),
        .WRITEDATA     (WRITEDATA),
        .READDATA      (READDATA),
        .BUSYWAIT      (BUSYWAIT),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory: busy for LAT cycles, completes on the following edge.
    logic [31:0] mem [64];
    logic [31:0] init_img [64];
    logic        mem_loaded = 1'b0;
    int          cnt;
    int          wb_cnt;
    logic [5:0]  last_wb_a;
    logic [31:0] last_wb_d;

    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt != LAT);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt <= 0;
            if (!mem_loaded) begin
                for (int i = 0; i < 64; i++) mem[i] <= init_img[i];
                mem_loaded <= 1'b1;
                wb_cnt <= 0;
            end
        end else if (MEM_READ | MEM_WRITE) begin
            if (cnt == LAT) begin
                cnt <= 0;
                if (MEM_WRITE) begin
                    mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                    wb_cnt    <= wb_cnt + 1;
                    last_wb_a <= MEM_ADDRESS;
                    last_wb_d <= MEM_WRITEDATA;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    task automatic chk(input string tg, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tg, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            chk("rd_wr_exclusive", {30'd0, MEM_READ, MEM_WRITE} != 32'd3, 1);
        end
    end

    // Reference model: cache contents plus backing memory image.
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] ref_mem [64];

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    function automatic void model_access(
        input  logic        wr,
        input  logic [7:0]  a,
        input  logic [7:0]  wd,
        output int          cyc,
        output logic [7:0]  rd,
        output logic        wb,
        output logic [5:0]  wb_a,
        output logic [31:0] wb_d,
        output logic [5:0]  fa
    );
        int i  = int'(a[4:2]);
        int sh = int'(a[1:0]) * 8;
        logic hit = m_valid[i] && (m_tag[i] == a[7:5]);
        wb   = !hit && m_valid[i] && m_dirty[i];
        wb_a = {m_tag[i], a[4:2]};
        wb_d = m_data[i];
        fa   = a[7:2];
        cyc  = hit ? 0 : (wb ? 2 * (LAT + 1) + 2 : (LAT + 1) + 2);
        if (!hit) begin
            if (wb) ref_mem[wb_a] = wb_d;
            m_data[i]  = ref_mem[a[7:2]];
            m_tag[i]   = a[7:5];
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
        end
        rd = 8'((m_data[i] >> sh) & 32'hFF);
        if (wr) begin
            m_data[i]  = (m_data[i] & ~(32'hFF << sh))
                       | ({24'd0, wd} << sh);
            m_dirty[i] = 1'b1;
        end
    endfunction

    task automatic access(input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] wd);
        int          exp_n;
        int          n = 0;
        int          wb0;
        logic [7:0]  exp_rd;
        logic        exp_wb;
        logic [5:0]  wb_a;
        logic [31:0] wb_d;
        logic [5:0]  fa;
        logic        seen_rd = 1'b0;
        model_access(wr, a, wd, exp_n, exp_rd, exp_wb, wb_a, wb_d, fa);
        @(negedge CLK);
        wb0 = wb_cnt;
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
        #1;
        chk("busy_on_issue", BUSYWAIT, exp_n != 0);
        while (BUSYWAIT && n < 100) begin
            @(posedge CLK); #1; n++;
            if (n == 1) begin
                chk("first_mem_write", MEM_WRITE, exp_wb);
                chk("first_mem_read", MEM_READ, !exp_wb);
                chk("first_mem_addr", MEM_ADDRESS, exp_wb ? wb_a : fa);
            end
            if (MEM_READ && !seen_rd) begin
                seen_rd = 1'b1;
                chk("fetch_addr", MEM_ADDRESS, fa);
            end
        end
        chk("busy_cycles", n, exp_n);
        chk("fetch_seen", seen_rd, exp_n != 0);
        chk("wb_count", wb_cnt - wb0, exp_wb);
        if (exp_wb) begin
            chk("wb_addr", last_wb_a, wb_a);
            chk("wb_data", last_wb_d, wb_d);
        end
        if (rd && !wr) chk("readdata", READDATA, exp_rd);
        @(posedge CLK); #1;
        READ = 1'b0; WRITE = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic [7:0]  r;
        logic        w;
        logic [5:0]  wa;
        logic [31:0] wdt;
        logic [5:0]  fa;
        for (int i = 0; i < 64; i++) init_img[i] = $urandom;
        init_img[0] = 32'h44332211;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_img[i];
        for (int i = 0; i < 8; i++) begin
            m_tag[i]  = 3'd0;
            m_data[i] = 32'd0;
        end
        model_reset();
        READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
        RESET = 1'b0;
        #1 RESET = 1'b1;
        #2;
        chk("rst_busy", BUSYWAIT, 0);
        chk("rst_mem_read", MEM_READ, 0);
        chk("rst_mem_write", MEM_WRITE, 0);
        READ = 1'b1; #1;
        chk("rst_busy_req", BUSYWAIT, 1);
        READ = 1'b0;
        @(negedge CLK); @(negedge CLK);
        RESET = 1'b0;

        // Cold miss, hits, write hit, dirty eviction.
        access(1, 0, 8'h00, 8'h00);
        access(1, 0, 8'h03, 8'h00);
        chk("hit_byte3", READDATA, 8'h44);
        access(0, 1, 8'h01, 8'hAA);
        chk("dirty0", dut.dirty_q[0], 1);
        access(1, 0, 8'h01, 8'h00);
        chk("read_aa", READDATA, 8'hAA);
        access(1, 0, 8'h20, 8'h00);
        chk("wb_block", last_wb_d, 32'h4433AA11);

        // Reset in the middle of a fetch.
        model_access(0, 8'h00, 8'h00, cyc, r, w, wa, wdt, fa);
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        chk("pre_rst_fetch", MEM_READ, 1);
        RESET = 1'b1; #1;
        chk("rst_fetch_rd", MEM_READ, 0);
        chk("rst_fetch_wr", MEM_WRITE, 0);
        chk("rst_state", dut.u_fsm.state_q, 0);
        chk("rst_fetch_busy", BUSYWAIT, 1);
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        access(1, 0, 8'h00, 8'h00);

        // READ and WRITE together act as a store.
        access(1, 1, 8'h02, 8'h5A);
        access(1, 0, 8'h02, 8'h00);
        chk("rw_5a", READDATA, 8'h5A);

        // Request withdrawn mid-miss still completes the fill.
        model_access(0, 8'h44, 8'h00, cyc, r, w, wa, wdt, fa);
        @(negedge CLK);
        READ = 1'b1; ADDRESS = 8'h44;
        repeat (2) @(posedge CLK);
        #1 READ = 1'b0;
        repeat (15) @(posedge CLK);
        #1;
        chk("drop_idle_rd", MEM_READ, 0);
        chk("drop_busy", BUSYWAIT, 0);
        access(1, 0, 8'h44, 8'h00);

        for (int k = 0; k < 200; k++) begin
            logic [7:0] a;
            int op;
            a  = {3'($urandom_range(0, 3)), 5'($urandom)};
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
